c17_response_compactor: RTL and testbench
=========================================

# c17_response_compactor

Downstream BIST stage for the c17 benchmark core. Consumes the two-bit response (outputs 22 and 23) of each applied test pattern and folds it into a 16-bit multiple-input signature register (MISR). It counts accepted patterns and, after a programmed number, compares the final signature against a golden value and reports pass/fail. It lets the combinational benchmark be exercised as a self-checking sequential test harness.

## Interface
- `SEED`, default 16'hFFFF: MISR value loaded at each run start.
- `POLY`, default 16'h1021: feedback polynomial, Galois form.
- `PATTERNS`, default 32: responses per run (32 = exhaustive over 5 inputs). Legal range 1..65535.
- `GOLDEN`, default 16'h0000: expected final signature. Overridden per build/bench.
- `clock` input, 1 bit: single clock; all state updates on its rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset. Sampled on the rising edge of `clock`.
- `start` input, 1 bit: one-cycle request to begin a run.
- `resp_valid` input, 1 bit: `resp` holds a valid response this cycle.
- `resp` input, 2 bits: [0] = output 22, [1] = output 23.
- `resp_ready` output, 1 bit: compactor accepts a response this cycle.
- `busy` output, 1 bit: high in RUN.
- `done` output, 1 bit: high in DONE.
- `pass` output, 1 bit: final signature equals `GOLDEN`. Valid only while `done` is high; otherwise 0.
- `signature` output, 16 bits: current MISR contents.
- `count` output, 16 bits: responses accepted in the current/last run.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset values (`reset_n` low at an edge):
  - state = IDLE
  - `signature` = `SEED`
  - `count` = 0
  - `pass` = 0
  - `done` = `busy` = `resp_ready` = 0
- IDLE:
  - `start` = 1 leads to RUN next cycle, with `signature` ← `SEED` and `count` ← 0.
- RUN:
  - `resp_ready` = 1.
  - A response is accepted when `resp_valid` and `resp_ready` are both high. On acceptance:
    - `signature` ← {`signature`[14:0], 1'b0} ^ (`signature`[15] ? `POLY` : 16'h0) ^ {14'b0, `resp`}
    - `count` ← `count` + 1
  - The acceptance that makes `count` equal `PATTERNS` moves the FSM to DONE on the same edge.
  - Beats with `resp_valid` low: no change.
  - `start` is ignored in RUN.
- DONE:
  - `resp_ready` = 0; `signature` and `count` hold.
  - `pass` = (`signature` == `GOLDEN`), registered on entry.
  - `start` = 1 leads to RUN next cycle, with `signature` reloaded, `count` cleared and `pass` cleared.
  - Otherwise the FSM stays in DONE indefinitely.
- `resp_valid` outside RUN: ignored. No acceptance, no state change.
- Reset mid-run: returns to IDLE with reset values on that edge; the partial signature is discarded.
- `count` arithmetic: 16-bit, never wraps, since `PATTERNS` ≤ 65535 ends the run first.

## Timing
- `start` to `busy` high: 1 cycle.
- Each accepted response updates `signature`/`count` on the same edge (1-cycle latency); throughput is 1 response/cycle.
- Last accepted response to `done` = 1 and `pass` valid: same edge (visible the next cycle).
- `start` in DONE to new run: `done` drops and `busy` rises on the next edge.
- Every output is a register or a direct decode of the FSM state; no combinational path from any input to any output.

## Configuration
- `C17_COMPACTOR_ABORT_EN` defined:
  - Adds input `abort` (1 bit). `abort` = 1 in RUN or DONE forces IDLE on the next edge.
  - `signature` and `count` hold their values for inspection; `pass` is cleared.
  - If `abort` and `start` are asserted together in DONE, `abort` wins.
- `C17_COMPACTOR_ABORT_EN` undefined: no `abort` port; the only exit from RUN is completion or reset.

## Test plan
- Reset: hold `reset_n` = 0 for 2 cycles, then release. Expect `signature` = 16'hFFFF, `count` = 0, `busy`/`done`/`pass`/`resp_ready` = 0.
- Single-pattern run, default `SEED`, `PATTERNS` = 1, `GOLDEN` = 16'hEFDF: pulse `start`, then `resp` = 2'b00 with `resp_valid`. Expect `signature` = 16'hEFDF, `count` = 1, `done` = 1, `pass` = 1.
- Single-pattern fail, `SEED` = 16'h0000, `GOLDEN` = 16'h0000: pulse `start`, then `resp` = 2'b11. Expect `signature` = 16'h0003, `done` = 1, `pass` = 0.
- Exhaustive run, `PATTERNS` = 32: drive c17 responses for inputs 0..31 with random `resp_valid` gaps. Expect `count` = 32 and `signature` equal to the bench model. Expect `done` exactly 1 cycle after the 32nd acceptance edge, and no acceptance while `resp_valid` = 0.
- Reset mid-run: assert `reset_n` = 0 after 10 accepted responses. Expect IDLE, `signature` = `SEED`, `count` = 0; a fresh run then gives the same result as an uninterrupted run.
- Restart/abort: `start` in DONE gives `busy` = 1 and `count` = 0 next cycle. With `C17_COMPACTOR_ABORT_EN` defined, `abort` at `count` = 5 gives IDLE with `count` still 5 and `pass` = 0.

Source files
------------

// File: rtl/c17_response_compactor.sv
// rtl/c17_response_compactor.sv - MISR response compactor for the c17 BIST harness
// Optional feature macro: C17_COMPACTOR_ABORT_EN (adds the abort input).
module c17_response_compactor #(
  parameter logic [15:0] SEED     = 16'hFFFF,
  parameter logic [15:0] POLY     = 16'h1021,
  parameter int          PATTERNS = 32,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
`ifdef C17_COMPACTOR_ABORT_EN
  input  logic        abort,
`endif
  input  logic        resp_valid,
  input  logic [1:0]  resp,
  output logic        resp_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LAST_COUNT = PATTERNS[15:0];

  state_t      state;
  logic [15:0] sig_q;
  logic [15:0] cnt_q;
  logic        pass_q;
  logic        abort_req;
  logic [15:0] sig_next;
  logic [15:0] cnt_next;

`ifdef C17_COMPACTOR_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Galois MISR step folding the two response bits into the low end
  always_comb begin
    sig_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {14'b0, resp};
    cnt_next = cnt_q + 16'd1;
  end

  // Run-control FSM with signature, count and verdict registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      sig_q  <= SEED;
      cnt_q  <= 16'd0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            sig_q  <= SEED;
            cnt_q  <= 16'd0;
            pass_q <= 1'b0;
          end
        end
        RUN: begin
          if (abort_req) begin
            // Signature and count are left in place for inspection
            state  <= IDLE;
            pass_q <= 1'b0;
          end else if (resp_valid) begin
            sig_q <= sig_next;
            cnt_q <= cnt_next;
            if (cnt_next == LAST_COUNT) begin
              state  <= DONE;
              pass_q <= (sig_next == GOLDEN);
            end
          end
        end
        DONE: begin
          if (abort_req) begin
            state  <= IDLE;
            pass_q <= 1'b0;
          end else if (start) begin
            state  <= RUN;
            sig_q  <= SEED;
            cnt_q  <= 16'd0;
            pass_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          pass_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are registers or plain decodes of the state register
  assign resp_ready = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign pass       = pass_q & (state == DONE);
  assign signature  = sig_q;
  assign count      = cnt_q;

endmodule

// File: tb/tb_c17_response_compactor.sv
// tb/tb_c17_response_compactor.sv - self-checking bench for c17_response_compactor
module tb_c17_response_compactor;

  localparam logic [15:0] POLY_TB = 16'h1021;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? POLY_TB : 16'h0000) ^ {14'b0, r};
  endfunction

  // c17 netlist: x[0..4] = inputs 1,2,3,6,7; returns {out23, out22}
  function automatic logic [1:0] c17(input int v);
    logic [4:0] x;
    logic n10, n11, n16, n19;
    x   = v[4:0];
    n10 = ~(x[0] & x[2]);
    n11 = ~(x[2] & x[3]);
    n16 = ~(x[1] & n11);
    n19 = ~(n11 & x[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [15:0] exh_sig();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < 32; i++) s = misr_step(s, c17(i));
    return s;
  endfunction

  localparam logic [15:0] GOLD_C = exh_sig();
  localparam logic [15:0] P_SEED [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
  localparam logic [15:0] P_PAT  [3] = '{16'd1, 16'd1, 16'd32};
  localparam logic [15:0] P_GOLD [3] = '{16'hEFDF, 16'h0000, GOLD_C};

  logic        clock = 1'b0;
  logic        reset_n, start, resp_valid;
  logic [1:0]  resp;
`ifdef C17_COMPACTOR_ABORT_EN
  logic        abort;
`endif
  logic        rdy [3];
  logic        bsy [3];
  logic        dn  [3];
  logic        ps  [3];
  logic [15:0] sg  [3];
  logic [15:0] ct  [3];

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clock = ~clock;

  c17_response_compactor #(.SEED(16'hFFFF), .PATTERNS(1), .GOLDEN(16'hEFDF)) u_a (
    .clock(clock), .reset_n(reset_n), .start(start),
`ifdef C17_COMPACTOR_ABORT_EN
    .abort(abort),
`endif
    .resp_valid(resp_valid), .resp(resp), .resp_ready(rdy[0]), .busy(bsy[0]),
    .done(dn[0]), .pass(ps[0]), .signature(sg[0]), .count(ct[0]));

  c17_response_compactor #(.SEED(16'h0000), .PATTERNS(1), .GOLDEN(16'h0000)) u_b (
    .clock(clock), .reset_n(reset_n), .start(start),
`ifdef C17_COMPACTOR_ABORT_EN
    .abort(abort),
`endif
    .resp_valid(resp_valid), .resp(resp), .resp_ready(rdy[1]), .busy(bsy[1]),
    .done(dn[1]), .pass(ps[1]), .signature(sg[1]), .count(ct[1]));

  c17_response_compactor #(.SEED(16'hFFFF), .PATTERNS(32), .GOLDEN(GOLD_C)) u_c (
    .clock(clock), .reset_n(reset_n), .start(start),
`ifdef C17_COMPACTOR_ABORT_EN
    .abort(abort),
`endif
    .resp_valid(resp_valid), .resp(resp), .resp_ready(rdy[2]), .busy(bsy[2]),
    .done(dn[2]), .pass(ps[2]), .signature(sg[2]), .count(ct[2]));

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1 = collecting, 2 = finished
  logic [1:0]  mph  [3];
  logic [15:0] msig [3];
  logic [15:0] mcnt [3];
  logic        mpass[3];
  logic        m_abort;

`ifdef C17_COMPACTOR_ABORT_EN
  assign m_abort = abort;
`else
  assign m_abort = 1'b0;
`endif

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        mph[i] <= 2'd0; msig[i] <= P_SEED[i]; mcnt[i] <= 16'd0; mpass[i] <= 1'b0;
      end else if (m_abort && mph[i] != 2'd0) begin
        mph[i] <= 2'd0; mpass[i] <= 1'b0;
      end else if (mph[i] != 2'd1) begin
        if (start) begin
          mph[i] <= 2'd1; msig[i] <= P_SEED[i]; mcnt[i] <= 16'd0; mpass[i] <= 1'b0;
        end
      end else if (resp_valid) begin
        msig[i] <= misr_step(msig[i], resp);
        mcnt[i] <= mcnt[i] + 16'd1;
        if (mcnt[i] + 16'd1 == P_PAT[i]) begin
          mph[i]   <= 2'd2;
          mpass[i] <= (misr_step(msig[i], resp) == P_GOLD[i]);
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model
  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("busy",       i, {15'b0, bsy[i]}, {15'b0, mph[i] == 2'd1});
        chk("resp_ready", i, {15'b0, rdy[i]}, {15'b0, mph[i] == 2'd1});
        chk("done",       i, {15'b0, dn[i]},  {15'b0, mph[i] == 2'd2});
        chk("pass",       i, {15'b0, ps[i]},  {15'b0, mpass[i] && mph[i] == 2'd2});
        chk("signature",  i, sg[i], msig[i]);
        chk("count",      i, ct[i], mcnt[i]);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic feed(input int n);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      resp_valid = 1'b0;
      resp = 2'(~k);
      repeat (gap) tick();
      resp_valid = 1'b1;
      resp = c17(k);
      tick();
    end
    resp_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; resp_valid = 1'b0; resp = 2'b00;
`ifdef C17_COMPACTOR_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_sig",  2, sg[2], 16'hFFFF);
    chk("rst_cnt",  2, ct[2], 16'd0);
    chk("rst_sigb", 1, sg[1], 16'h0000);
    chk("rst_flags", 0, {12'b0, bsy[0], dn[0], ps[0], rdy[0]}, 16'h0);
    reset_n = 1'b1;

    // Single pattern, response 00
    pulse_start();
    resp_valid = 1'b1; resp = 2'b00;
    tick();
    resp_valid = 1'b0;
    chk("a_sig",  0, sg[0], 16'hEFDF);
    chk("a_cnt",  0, ct[0], 16'd1);
    chk("a_done", 0, {15'b0, dn[0]}, 16'd1);
    chk("a_pass", 0, {15'b0, ps[0]}, 16'd1);
    tick();
    chk("a_hold", 0, sg[0], 16'hEFDF);

    // Single pattern, response 11
    pulse_start();
    resp_valid = 1'b1; resp = 2'b11;
    tick();
    resp_valid = 1'b0;
    chk("b_sig",  1, sg[1], 16'h0003);
    chk("b_done", 1, {15'b0, dn[1]}, 16'd1);
    chk("b_pass", 1, {15'b0, ps[1]}, 16'd0);
    chk("a_sig2", 0, sg[0], 16'hEFDC);
    chk("a_pass2", 0, {15'b0, ps[0]}, 16'd0);

    // Exhaustive run with random gaps
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    pulse_start();
    feed(32);
    chk("c_cnt",  2, ct[2], 16'd32);
    chk("c_done", 2, {15'b0, dn[2]}, 16'd1);
    chk("c_pass", 2, {15'b0, ps[2]}, 16'd1);
    chk("c_sig",  2, sg[2], GOLD_C);

    // Reset mid-run, then an uninterrupted run
    pulse_start();
    feed(10);
    chk("mid_cnt", 2, ct[2], 16'd10);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_sig", 2, sg[2], 16'hFFFF);
    chk("mid_rst_cnt", 2, ct[2], 16'd0);
    chk("mid_rst_busy", 2, {15'b0, bsy[2]}, 16'd0);
    reset_n = 1'b1;
    tick();
    pulse_start();
    feed(32);
    chk("rerun_sig",  2, sg[2], GOLD_C);
    chk("rerun_pass", 2, {15'b0, ps[2]}, 16'd1);

    // Restart from DONE
    pulse_start();
    chk("restart_busy", 2, {15'b0, bsy[2]}, 16'd1);
    chk("restart_cnt",  2, ct[2], 16'd0);
    chk("restart_done", 2, {15'b0, dn[2]}, 16'd0);

`ifdef C17_COMPACTOR_ABORT_EN
    feed(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cnt",  2, ct[2], 16'd5);
    chk("abort_busy", 2, {15'b0, bsy[2]}, 16'd0);
    chk("abort_done", 2, {15'b0, dn[2]}, 16'd0);
    chk("abort_pass", 2, {15'b0, ps[2]}, 16'd0);
    tick();
`else
    feed(32);
    chk("final_sig", 2, sg[2], GOLD_C);
`endif

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
